// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic register slice for a valid/ready stream; both in_ready and out_data come from flops.
// Optional synchronous flush port and logic are enabled with `define SKID_FLUSH_EN.
module pipe_skid_buffer #(
    parameter int unsigned N = 1
) (
    input  logic         clock,
    input  logic         rstN,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
`ifdef SKID_FLUSH_EN
    ,
    input  logic         flush
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_d;
    logic [N-1:0] main_q;
    logic [N-1:0] main_d;
    logic [N-1:0] skid_q;
    logic [N-1:0] skid_d;
    logic         in_xfer_c;
    logic         out_xfer_c;

    assign in_xfer_c  = in_valid & in_ready;
    assign out_xfer_c = out_valid & out_ready;
    assign out_data   = main_q;

    // Next-state and data-path steering
    always_comb begin
        state_d = state;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state)
            EMPTY: begin
                if (in_xfer_c) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer_c && out_xfer_c) begin
                    main_d = in_data;
                end else if (in_xfer_c) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_xfer_c) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer_c) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
`ifdef SKID_FLUSH_EN
        // Flush wins over any transfer; held data registers are left as they are
        if (flush) begin
            state_d = EMPTY;
        end
`endif
    end

    // Handshake outputs are re-derived from the next state so both stay pure flops
    always_ff @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            in_ready  <= (state_d != FULL);
            out_valid <= (state_d != EMPTY);
        end
    end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed and randomized checks for pipe_skid_buffer with N=8.
// Flush scenarios are compiled in when SKID_FLUSH_EN is defined.
module tb_pipe_skid_buffer;

    logic       clock;
    logic       rstN;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef SKID_FLUSH_EN
    logic       flush;
`endif

    int checks;
    int errors;

    pipe_skid_buffer #(.N(8)) dut (
        .clock     (clock),
        .rstN      (rstN),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SKID_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1ns past it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_initial: out_valid=%b in_ready=%b out_data=%h, required 0 0 00",
                     out_valid, in_ready, out_data);
        end
        step();
        rstN = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hEE;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, required 0", in_ready);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge: in_ready=%b out_valid=%b, required 1 0",
                     in_ready, out_valid);
        end
        // Fill to FULL with 0x33, 0x44, then reset mid-stream
        out_ready = 1'b0;
        in_data = 8'h33;
        step();
        in_data = 8'h44;
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h33) begin
            errors++;
            $display("FAIL reset_prefill_full: in_ready=%b out_valid=%b out_data=%h, required 0 1 33",
                     in_ready, out_valid, out_data);
        end
        #1 rstN = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_midstream: out_valid=%b in_ready=%b out_data=%h, required 0 0 00",
                     out_valid, in_ready, out_data);
        end
        #1 rstN = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_after_release: in_ready=%b out_valid=%b, required 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = 8'(i);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i) || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_word_%0d: out_valid=%b out_data=%h in_ready=%b, required 1 %h 1",
                         i, out_valid, out_data, in_ready, 8'(i));
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_end_empty: out_valid=%b in_ready=%b, required 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_skid_fill();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL skid_busy: out_valid=%b out_data=%h in_ready=%b, required 1 a1 1",
                     out_valid, out_data, in_ready);
        end
        in_data = 8'hA2;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL skid_full: out_valid=%b out_data=%h in_ready=%b, required 1 a1 0",
                     out_valid, out_data, in_ready);
        end
        // Offered word while in_ready=0 must be ignored
        in_data = 8'hFF;
        step();
        checks++;
        if (out_data !== 8'hA1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL skid_stall_hold: out_data=%h in_ready=%b, required a1 0",
                     out_data, in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA1) begin
            errors++;
            $display("FAIL skid_emit_first: out_valid=%b out_data=%h, required 1 a1",
                     out_valid, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL skid_emit_second: out_valid=%b out_data=%h in_ready=%b, required 1 a2 1",
                     out_valid, out_data, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL skid_drained: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h55;
        step();
        in_data = 8'h66;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_first: out_valid=%b out_data=%h in_ready=%b, required 1 55 0",
                     out_valid, out_data, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h66) begin
            errors++;
            $display("FAIL drain_second: out_valid=%b out_data=%h, required 1 66",
                     out_valid, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: out_valid=%b in_ready=%b, required 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_stress();
        logic [7:0] q[$];
        logic [7:0] next_word;
        logic [7:0] prev_data;
        logic       prev_stall;
        logic       ix;
        logic       ox;
        logic       exp_valid;
        next_word = 8'h00;
        prev_data = 8'h00;
        prev_stall = 1'b0;
        for (int cyc = 0; cyc < 10040; cyc++) begin
            if (cyc < 10000) begin
                in_valid = 1'($urandom_range(1, 0));
                out_ready = 1'($urandom_range(1, 0));
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            in_data = next_word;
            exp_valid = (q.size() != 0);
            checks++;
            if (out_valid !== exp_valid || in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL stress_flags cyc %0d: out_valid=%b in_ready=%b, required %b %b",
                         cyc, out_valid, in_ready, exp_valid, (q.size() < 2));
            end
            if (exp_valid) begin
                checks++;
                if (out_data !== q[0]) begin
                    errors++;
                    $display("FAIL stress_order cyc %0d: out_data=%h, required %h", cyc, out_data, q[0]);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stress_stable cyc %0d: out_data=%h, required %h", cyc, out_data, prev_data);
                end
            end
            ix = in_valid && (q.size() < 2);
            ox = exp_valid && out_ready;
            prev_stall = exp_valid && !out_ready;
            prev_data = out_data;
            step();
            if (ox) void'(q.pop_front());
            if (ix) begin
                q.push_back(next_word);
                next_word = next_word + 8'd1;
            end
        end
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stress_final_empty: model words=%0d out_valid=%b, required 0 0",
                     q.size(), out_valid);
        end
    endtask

`ifdef SKID_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h11;
        step();
        in_data = 8'h22;
        step();
        flush = 1'b1;
        out_ready = 1'b1;
        in_data = 8'h99;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_emit: out_valid=%b out_data=%h, required 0", out_valid, out_data);
        end
        // Flush in BUSY while a word is accepted: that word is discarded too
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h77;
        step();
        flush = 1'b1;
        in_data = 8'h88;
        step();
        flush = 1'b0;
        in_data = 8'h12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h12) begin
            errors++;
            $display("FAIL flush_resume: out_valid=%b out_data=%h, required 1 12", out_valid, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_resume_empty: out_valid=%b, required 0", out_valid);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rstN = 1'b0;
        in_data = 8'h00;
        in_valid = 1'b0;
        out_ready = 1'b0;
`ifdef SKID_FLUSH_EN
        flush = 1'b0;
`endif
        #2;
        test_reset();
        test_streaming();
        test_skid_fill();
        test_drain();
        test_stress();
`ifdef SKID_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
